mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit, the next step after the single-cycle datapath.
- Drives the shared datapath control fields, including the 4-bit ALUOp into the ALU, each cycle.
- Consumes the ALU's Zero flag to resolve beq.
- Sequences fetch, decode, execute, memory and writeback across cycles, and stalls on a memory ready handshake.

Parameters:
- FETCH_ONLY_RETRY, 1: when 1, FETCH re-asserts mem_re every cycle until mem_ready; when 0, mem_re is a single-cycle pulse on FETCH entry.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Op  in  6  IR[31:26]; the IR is stable outside FETCH.
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU equality flag, (A==B).
- mem_ready  in  1  memory has completed the current read or write this cycle.
- ALUOp  out  4  0000 and, 0001 or, 0010 add, 0011 sub, 0101 xor.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  0 = register B, 1 = const 4, 2 = ext(imm16), 3 = sext(imm16)<<2.
- ExtOp  out  1  0 = zero-extend, 1 = sign-extend.
- RegDst  out  2  0 = rt, 1 = rd, 2 = $31.
- WDSel  out  2  0 = ALUOut, 1 = MDR, 2 = imm16<<16, 3 = PC.
- NPCSel  out  2  0 = ALU result, 1 = ALUOut, 2 = {PC[31:28], imm26, 00}, 3 = register A.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  IR load enable.
- RegWrite  out  1  register file write enable.
- mem_re  out  1  memory read request.
- mem_we  out  1  memory write request.
- retire  out  1  one-cycle pulse in the last cycle of each legal instruction.
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode/funct.
- state  out  4  current state, for debug.

Behaviour:
- State register is the only storage, plus a 1-bit fetch_issued flag used when FETCH_ONLY_RETRY=0.
- Outputs are decoded from state, Op and Funct (Moore plus IR fields).
- Defaults for all unlisted outputs: 0, with ALUOp=0010.
- Reset:
  - Reset high -> next state is FETCH (0).
  - While reset is high, PCWrite, IRWrite, RegWrite, mem_re, mem_we, retire and illegal are forced to 0.
  - Reset mid-instruction abandons it with no writes in that cycle.
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_ORI=3, MEMADR=4, MEMRD=5, MEMWB=6, MEMWR=7, WB=8, BRANCH=9, JUMP=10, JR=11.
- Supported instructions:
  - R-type (Op=000000) with Funct addu 100001, subu 100011, and 100100, or 100101, xor 100110, jr 001000.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- FETCH:
  - mem_re=1; ALUSrcA=0, ALUSrcB=1, add, NPCSel=0.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH while !mem_ready; go to DECODE on mem_ready.
- DECODE:
  - ALUSrcA=0 (PC already +4), ALUSrcB=3, ExtOp=1, add; ALUOut latches the branch target.
  - Next state: R-ALU -> EXEC_R; jr -> JR; ori -> EXEC_ORI; lui -> WB; lw/sw -> MEMADR; beq -> BRANCH; j/jal -> JUMP.
  - Anything else -> FETCH with illegal=1 and no writes.
- EXEC_R: ALUSrcA=1, ALUSrcB=0; ALUOp mapped from Funct (addu 0010, subu 0011, and 0000, or 0001, xor 0101). Next: WB.
- EXEC_ORI: ALUSrcA=1, ALUSrcB=2, ExtOp=0, ALUOp=0001. Next: WB.
- WB:
  - RegWrite=1, retire=1. Next: FETCH.
  - R-type: RegDst=1, WDSel=0.
  - ori: RegDst=0, WDSel=0.
  - lui: RegDst=0, WDSel=2.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ExtOp=1, add. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_re=1; hold until mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, WDSel=1, retire=1. Next: FETCH.
- MEMWR:
  - mem_we=1, held every cycle until mem_ready.
  - The write commits on the mem_ready cycle, which also has retire=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=0011, NPCSel=1, PCWrite=Zero, retire=1. Next: FETCH.
- JUMP:
  - NPCSel=2, PCWrite=1, retire=1. Next: FETCH.
  - jal additionally drives RegWrite=1, RegDst=2, WDSel=3.
- JR: NPCSel=3, PCWrite=1, retire=1. Next: FETCH.
- Latency with mem_ready always 1:
  - R/ori/lui/beq/j/jal/jr: 3 or 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle with mem_ready low adds exactly 1 cycle.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Simultaneous reset and mem_ready: reset wins.
- FETCH_ONLY_RETRY=0: mem_re is high only in the first FETCH cycle after entry; IRWrite still waits for mem_ready.

Test Plan:
- reset held 3 cycles then released, mem_ready=1, Op=000000/Funct=100001 -> states 0,1,2,8,0; ALUOp 0010 in state 2; RegWrite=1, RegDst=1 only in state 8; retire pulses once.
- lw (Op=100011) with mem_ready low for 2 cycles in MEMRD -> MEMRD lasts 3 cycles, mem_re=1 throughout; MEMWB asserts RegWrite, WDSel=1; total 7 cycles.
- beq (Op=000100): once with Zero=1 and once with Zero=0 -> in BRANCH ALUOp=0011 and NPCSel=1; PCWrite=1 in the Zero=1 case, 0 in the Zero=0 case.
- jal (Op=000011) -> in JUMP: PCWrite=1, NPCSel=2, RegWrite=1, RegDst=2, WDSel=3.
- Op=111111 -> DECODE returns to FETCH; illegal=1 for one cycle; no RegWrite, PCWrite or mem_we asserted.
- sw with mem_ready low, then reset asserted while in MEMWR -> next state FETCH; mem_we=0 during the reset cycle; no retire.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control-unit bundle: IR fields, ALU flag and memory handshake in,
// datapath control fields and status strobes out.
interface mc_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic [3:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtOp;
    logic [1:0] RegDst;
    logic [1:0] WDSel;
    logic [1:0] NPCSel;
    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       mem_re;
    logic       mem_we;
    logic       retire;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  Op, Funct, Zero, mem_ready,
        output ALUOp, ALUSrcA, ALUSrcB, ExtOp, RegDst, WDSel, NPCSel,
               PCWrite, IRWrite, RegWrite, mem_re, mem_we, retire, illegal, state
    );

    modport slave (
        output Op, Funct, Zero, mem_ready,
        input  ALUOp, ALUSrcA, ALUSrcB, ExtOp, RegDst, WDSel, NPCSel,
               PCWrite, IRWrite, RegWrite, mem_re, mem_we, retire, illegal, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// and decodes datapath control from the current state and IR fields.
module mc_ctrl #(
    parameter bit FETCH_ONLY_RETRY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    mc_ctrl_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_ORI = 4'd3,
        S_MEMADR   = 4'd4,
        S_MEMRD    = 4'd5,
        S_MEMWB    = 4'd6,
        S_MEMWR    = 4'd7,
        S_WB       = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JR       = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0101;

    state_t state_q;
    state_t state_d;
    logic   fetch_issued;

    function automatic logic is_r_alu(input logic [5:0] fn);
        return (fn == FN_ADDU) || (fn == FN_SUBU) || (fn == FN_AND) ||
               (fn == FN_OR)   || (fn == FN_XOR);
    endfunction

    function automatic logic [3:0] alu_of_funct(input logic [5:0] fn);
        case (fn)
            FN_SUBU: return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: begin
                if (is_r_alu(fn))     return S_EXEC_R;
                else if (fn == FN_JR) return S_JR;
                else                  return S_FETCH;
            end
            OP_ORI:          return S_EXEC_ORI;
            OP_LUI:          return S_WB;
            OP_LW, OP_SW:    return S_MEMADR;
            OP_BEQ:          return S_BRANCH;
            OP_J, OP_JAL:    return S_JUMP;
            default:         return S_FETCH;
        endcase
    endfunction

    // State register; fetch_issued remembers that the single read pulse went out.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            fetch_issued <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_issued <= (state_q == S_FETCH) && !bus.mem_ready;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = decode_next(bus.Op, bus.Funct);
            S_EXEC_R:   state_d = S_WB;
            S_EXEC_ORI: state_d = S_WB;
            S_MEMADR:   state_d = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:    state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        bus.ALUOp    = ALU_ADD;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'd0;
        bus.ExtOp    = 1'b0;
        bus.RegDst   = 2'd0;
        bus.WDSel    = 2'd0;
        bus.NPCSel   = 2'd0;
        bus.PCWrite  = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.RegWrite = 1'b0;
        bus.mem_re   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.retire   = 1'b0;
        bus.illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_re  = FETCH_ONLY_RETRY ? 1'b1 : !fetch_issued;
                bus.ALUSrcB = 2'd1;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            // PC already holds PC+4, so PC + (sext(imm)<<2) is the branch target.
            S_DECODE: begin
                bus.ALUSrcB = 2'd3;
                bus.ExtOp   = 1'b1;
                bus.illegal = (decode_next(bus.Op, bus.Funct) == S_FETCH);
            end
            S_EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = alu_of_funct(bus.Funct);
            end
            S_EXEC_ORI: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'd2;
                bus.ALUOp   = ALU_OR;
            end
            S_WB: begin
                bus.RegWrite = 1'b1;
                bus.retire   = 1'b1;
                if (bus.Op == OP_RTYPE)    bus.RegDst = 2'd1;
                else if (bus.Op == OP_LUI) bus.WDSel  = 2'd2;
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'd2;
                bus.ExtOp   = 1'b1;
            end
            S_MEMRD: bus.mem_re = 1'b1;
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.WDSel    = 2'd1;
                bus.retire   = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_we = 1'b1;
                bus.retire = bus.mem_ready;
            end
            S_BRANCH: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALU_SUB;
                bus.NPCSel  = 2'd1;
                bus.PCWrite = bus.Zero;
                bus.retire  = 1'b1;
            end
            S_JUMP: begin
                bus.NPCSel  = 2'd2;
                bus.PCWrite = 1'b1;
                bus.retire  = 1'b1;
                if (bus.Op == OP_JAL) begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 2'd2;
                    bus.WDSel    = 2'd3;
                end
            end
            S_JR: begin
                bus.NPCSel  = 2'd3;
                bus.PCWrite = 1'b1;
                bus.retire  = 1'b1;
            end
            default: ;
        endcase
        // Reset abandons the current instruction: no side effects this cycle.
        if (reset) begin
            bus.PCWrite  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.RegWrite = 1'b0;
            bus.mem_re   = 1'b0;
            bus.mem_we   = 1'b0;
            bus.retire   = 1'b0;
            bus.illegal  = 1'b0;
        end
    end

    assign bus.state = state_q;

endmodule
